// File: rtl/dmem_arbiter_if.sv
// Bus bundle tying the two requesters, the arbiter and the single-port data memory together.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_gnt;
    logic                  p0_done;
    logic                  p0_err;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_gnt;
    logic                  p1_done;
    logic                  p1_err;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_done, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_done, p1_err, p1_rdata,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_done, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_done, p1_err, p1_rdata,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port data memory.
// One access in flight at a time: IDLE -> ACCESS -> DONE -> IDLE.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_DEPTH  = 64
) (
    input logic           clock,
    input logic           reset_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    state_t                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  we_q;
    logic                  in_range_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            gnt_q;
    logic [1:0]            done_q;
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  mem_write_q;
    logic                  mem_read_q;

    logic                  any_req_d;
    logic                  winner_d;
    logic                  we_d;
    logic                  in_range_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] rdata_cap_d;

    // Winner selection: a lone requester always wins; on contention the port
    // that was not granted last goes first.
    always_comb begin
        any_req_d = bus.p0_req | bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            winner_d = ~last_grant_q;
        end else begin
            winner_d = bus.p1_req;
        end
        we_d        = winner_d ? bus.p1_we    : bus.p0_we;
        addr_d      = winner_d ? bus.p1_addr  : bus.p0_addr;
        wdata_d     = winner_d ? bus.p1_wdata : bus.p0_wdata;
        in_range_d  = addr_d < DEPTH_A;
        rdata_cap_d = in_range_q ? bus.mem_read_data : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            in_range_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        state_q      <= S_ACCESS;
                        owner_q      <= winner_d;
                        last_grant_q <= winner_d;
                        we_q         <= we_d;
                        in_range_q   <= in_range_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        gnt_q        <= winner_d ? 2'b10 : 2'b01;
                        // Out-of-range accesses never strobe the memory.
                        mem_write_q  <= we_d & in_range_d;
                        mem_read_q   <= ~we_d & in_range_d;
                    end
                end
                S_ACCESS: begin
                    state_q     <= S_DONE;
                    gnt_q       <= 2'b00;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    done_q      <= owner_q ? 2'b10 : 2'b01;
                    err_q       <= in_range_q ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_q <= rdata_cap_d;
                        end else begin
                            rdata0_q <= rdata_cap_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 2'b00;
                    err_q   <= 2'b00;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_gnt   = gnt_q[0];
    assign bus.p1_gnt   = gnt_q[1];
    assign bus.p0_done  = done_q[0];
    assign bus.p1_done  = done_q[1];
    assign bus.p0_err   = err_q[0];
    assign bus.p1_err   = err_q[1];
    assign bus.p0_rdata = rdata0_q;
    assign bus.p1_rdata = rdata1_q;

    // Strobes are masked by reset_n so a reset edge landing on ACCESS drops the write.
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_write      = mem_write_q & reset_n;
    assign bus.mem_read       = mem_read_q & reset_n;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: transaction-level reference model with per-cycle checking.
module tb_dmem_arbiter;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int DEPTH = 64;
    localparam logic [63:0] DEPTH64 = 64'd64;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory attached to the arbiter.
    logic [DW-1:0] ram [DEPTH];
    assign bus.mem_read_data = (bus.mem_address < DEPTH64) ? ram[bus.mem_address[5:0]] : '0;
    always @(posedge clock) begin
        if (bus.mem_write === 1'b1 && bus.mem_address < DEPTH64)
            ram[bus.mem_address[5:0]] <= bus.mem_write_data;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction accepted at edge s is granted in cycle s,
    // completes at edge s+1 (done in cycle s+1) and the next pick is at edge s+3.
    int          k = 0;
    bit          mv = 1'b0;
    bit          act = 1'b0;
    int          s = 0;
    int          next_arb = 0;
    bit          lg = 1'b1;
    bit          t_port = 1'b0;
    bit          t_we = 1'b0;
    logic [63:0] t_addr = '0;
    logic [63:0] t_wdata = '0;
    logic [63:0] m_rd [2];
    logic [63:0] la = '0;
    logic [63:0] lw = '0;
    logic [63:0] mdl_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            mdl_mem[i] = '0;
        end
        m_rd[0] = '0;
        m_rd[1] = '0;
    end

    always @(posedge clock) begin
        k = k + 1;
        if (!reset_n) begin
            mv = 1'b1;
            act = 1'b0;
            lg = 1'b1;
            m_rd[0] = '0;
            m_rd[1] = '0;
            la = '0;
            lw = '0;
            next_arb = k + 1;
        end else if (mv) begin
            if (act && k == s + 1) begin
                if (t_we && t_addr < DEPTH64) mdl_mem[t_addr[5:0]] = t_wdata;
                if (!t_we) m_rd[t_port] = (t_addr < DEPTH64) ? mdl_mem[t_addr[5:0]] : '0;
            end
            if (act && k == s + 2) act = 1'b0;
            if (k >= next_arb && (bus.p0_req || bus.p1_req)) begin
                if (bus.p0_req && bus.p1_req) t_port = ~lg;
                else t_port = bus.p1_req;
                t_we    = t_port ? bus.p1_we    : bus.p0_we;
                t_addr  = t_port ? bus.p1_addr  : bus.p0_addr;
                t_wdata = t_port ? bus.p1_wdata : bus.p0_wdata;
                lg = t_port;
                la = t_addr;
                lw = t_wdata;
                act = 1'b1;
                s = k;
                next_arb = k + 3;
            end
        end
    end

    int wr_strobes = 0;
    int rd_strobes = 0;

    always @(negedge clock) begin
        bit g;
        bit d;
        bit inr;
        if (mv) begin
            g = act && (k == s);
            d = act && (k == s + 1);
            inr = t_addr < DEPTH64;
            chk1("p0_gnt", bus.p0_gnt, g && !t_port);
            chk1("p1_gnt", bus.p1_gnt, g && t_port);
            chk1("p0_done", bus.p0_done, d && !t_port);
            chk1("p1_done", bus.p1_done, d && t_port);
            chk1("p0_err", bus.p0_err, d && !t_port && !inr);
            chk1("p1_err", bus.p1_err, d && t_port && !inr);
            chk1("mem_write", bus.mem_write, g && t_we && inr && reset_n);
            chk1("mem_read", bus.mem_read, g && !t_we && inr && reset_n);
            chk64("p0_rdata", bus.p0_rdata, m_rd[0]);
            chk64("p1_rdata", bus.p1_rdata, m_rd[1]);
            chk64("mem_address", bus.mem_address, la);
            chk64("mem_write_data", bus.mem_write_data, lw);
            if (bus.mem_write === 1'b1) wr_strobes++;
            if (bus.mem_read === 1'b1) rd_strobes++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit p, input bit r, input bit we, input logic [63:0] a, input logic [63:0] d);
        if (p) begin
            bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end else begin
            bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end
    endtask

    function automatic logic gnt_of(input bit p);
        return p ? bus.p1_gnt : bus.p0_gnt;
    endfunction

    function automatic logic req_of(input bit p);
        return p ? bus.p1_req : bus.p0_req;
    endfunction

    task automatic do_req(input bit p, input bit we, input logic [63:0] a, input logic [63:0] d,
                          output int lat, output logic dn, output logic er, output logic [63:0] rd);
        drive(p, 1'b1, we, a, d);
        lat = 0;
        do begin
            step();
            lat++;
        end while (gnt_of(p) !== 1'b1 && lat < 20);
        chk1("gnt_wait", gnt_of(p), 1'b1);
        step();
        drive(p, 1'b0, 1'b0, '0, '0);
        dn = p ? bus.p1_done : bus.p0_done;
        er = p ? bus.p1_err : bus.p0_err;
        rd = p ? bus.p1_rdata : bus.p0_rdata;
        step();
    endtask

    function automatic logic [63:0] rnd_addr();
        int unsigned sel = $urandom_range(9, 0);
        if (sel <= 6) return 64'($urandom_range(15, 0));
        if (sel == 7) return 64'd63;
        if (sel == 8) return 64'd64;
        return {$urandom, $urandom} | 64'h0000_0100_0000_0000;
    endfunction

    initial begin
        int          lat;
        logic        dn;
        logic        er;
        logic [63:0] rd;
        int          order[$];
        int          exp_ord[4] = '{0, 1, 0, 1};
        int          first_lat;
        int          wr0;
        int          st0;
        int          n;

        // Reset with both requesters active.
        drive(1'b0, 1'b1, 1'b0, 64'd1, '0);
        drive(1'b1, 1'b1, 1'b0, 64'd2, '0);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("rst_p0_gnt", bus.p0_gnt, 1'b0);
            chk1("rst_p1_gnt", bus.p1_gnt, 1'b0);
            chk1("rst_p0_done", bus.p0_done, 1'b0);
            chk1("rst_mem_write", bus.mem_write, 1'b0);
            chk1("rst_mem_read", bus.mem_read, 1'b0);
        end

        // Contention with both requests held: p0 first, then alternation.
        reset_n = 1'b1;
        first_lat = -1;
        for (int i = 1; i <= 30 && order.size() < 4; i++) begin
            step();
            if (bus.p0_gnt === 1'b1) order.push_back(0);
            if (bus.p1_gnt === 1'b1) order.push_back(1);
            if (first_lat < 0 && order.size() > 0) first_lat = i;
        end
        chk64("t3_first_lat", 64'(first_lat), 64'd1);
        chk64("t3_grants", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk64("t3_order", 64'(order[i]), 64'(exp_ord[i]));
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step();

        // Write then read back on port 0.
        wr0 = wr_strobes;
        do_req(1'b0, 1'b1, 64'd5, 64'hDEAD, lat, dn, er, rd);
        chk64("t2_wr_lat", 64'(lat), 64'd1);
        chk1("t2_wr_done", dn, 1'b1);
        chk1("t2_wr_err", er, 1'b0);
        chk64("t2_wr_strobes", 64'(wr_strobes - wr0), 64'd1);
        do_req(1'b0, 1'b0, 64'd5, '0, lat, dn, er, rd);
        chk64("t2_rd_lat", 64'(lat), 64'd1);
        chk1("t2_rd_done", dn, 1'b1);
        chk1("t2_rd_err", er, 1'b0);
        chk64("t2_rdata", rd, 64'hDEAD);

        // Out-of-range reads on port 1 clear rdata and never strobe memory.
        do_req(1'b1, 1'b1, 64'd9, 64'h5A5A, lat, dn, er, rd);
        do_req(1'b1, 1'b0, 64'd9, '0, lat, dn, er, rd);
        chk64("t4_pre_rdata", rd, 64'h5A5A);
        st0 = wr_strobes + rd_strobes;
        do_req(1'b1, 1'b0, 64'd64, '0, lat, dn, er, rd);
        chk1("t4_64_done", dn, 1'b1);
        chk1("t4_64_err", er, 1'b1);
        chk64("t4_64_rdata", rd, 64'd0);
        do_req(1'b1, 1'b0, 64'h0000_0100_0000_0000, '0, lat, dn, er, rd);
        chk1("t4_big_err", er, 1'b1);
        chk64("t4_big_rdata", rd, 64'd0);
        chk64("t4_strobes", 64'(wr_strobes + rd_strobes - st0), 64'd0);

        // Reset lands on the ACCESS cycle of a write: the write is lost.
        do_req(1'b0, 1'b1, 64'd3, 64'h1111, lat, dn, er, rd);
        drive(1'b0, 1'b1, 1'b1, 64'd3, 64'h2222);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.p0_gnt !== 1'b1 && n < 20);
        chk1("t5_gnt", bus.p0_gnt, 1'b1);
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk1("t5_wr_gated", bus.mem_write, 1'b0);
        step();
        chk1("t5_no_done", bus.p0_done, 1'b0);
        reset_n = 1'b1;
        do_req(1'b0, 1'b0, 64'd3, '0, lat, dn, er, rd);
        chk64("t5_rdata", rd, 64'h1111);

        // A write leaves the previous read result in place.
        do_req(1'b0, 1'b1, 64'd7, 64'hBEEF, lat, dn, er, rd);
        do_req(1'b0, 1'b0, 64'd7, '0, lat, dn, er, rd);
        chk64("t6_read", rd, 64'hBEEF);
        do_req(1'b0, 1'b1, 64'd8, 64'h1234, lat, dn, er, rd);
        chk1("t6_wr_done", dn, 1'b1);
        chk64("t6_rdata_kept", rd, 64'hBEEF);

        // Random traffic from both ports with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (req_of(p[0]) === 1'b1) begin
                    if (gnt_of(p[0]) === 1'b1) begin
                        if ($urandom_range(1, 0) == 1)
                            drive(p[0], 1'b1, 1'($urandom_range(1, 0)), rnd_addr(), {$urandom, $urandom});
                        else
                            drive(p[0], 1'b0, 1'b0, '0, '0);
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    drive(p[0], 1'b1, 1'($urandom_range(1, 0)), rnd_addr(), {$urandom, $urandom});
                end
            end
            reset_n = ($urandom_range(199, 0) != 0);
            step();
        end

        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
